key_scan: RTL and testbench

//   4x4 matrix keypad scanner: the input-side counterpart of the digit-scanning display path.

---
 rtl/key_scan.sv | 199 +++++++++++++++++++
 tb/tb_key_scan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronized column sampling,
// frame-level debounce, and a nibble shift register of accepted key codes.
module key_scan #(
  parameter int CLK_IN_FREQ     = 1000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int DIG_WIDTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             col_i,
  input  logic                   clr_i,
  output logic [3:0]             row_o,
  output logic                   key_valid_o,
  output logic [3:0]             key_code_o,
  output logic                   key_down_o,
  output logic [DIG_WIDTH*4-1:0] key_data_o,
  output logic [1:0]             dbg_state_o
);

  localparam int PRESC_TC = CLK_IN_FREQ / SCAN_HZ - 1;
  localparam int PW       = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
  localparam int CW       = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_TC_V = PW'(PRESC_TC);
  localparam logic [CW-1:0] DEB_V      = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             col_s1_q, col_s2_q;
  logic [PW-1:0]          presc_q, presc_d;
  logic [3:0]             row_q, row_d;
  logic [1:0]             row_idx_q, row_idx_d;
  logic [1:0]             fr_cnt_q, fr_cnt_d;
  logic [3:0]             fr_code_q, fr_code_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             cand_q, cand_d;
  logic                   key_valid_q, key_valid_d;
  logic [3:0]             key_code_q, key_code_d;
  logic                   key_down_q, key_down_d;
  logic [DIG_WIDTH*4-1:0] key_data_q, key_data_d;

  logic                   tick;
  logic [3:0]             row_low;
  logic [2:0]             row_n;
  logic [1:0]             col_idx;
  logic [1:0]             base_cnt;
  logic [2:0]             sum_cnt;
  logic [1:0]             frame_cnt;
  logic [3:0]             frame_code;
  logic                   frame_done;
  logic                   press_evt;
  logic [CW-1:0]          cnt_inc;
  logic [DIG_WIDTH*4+3:0] shifted;

  // Scan timing and per-row accumulation into a frame result (0, 1 or 2+ keys).
  always_comb begin
    tick      = (presc_q == PRESC_TC_V);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    fr_cnt_d  = fr_cnt_q;
    fr_code_d = fr_code_q;
    row_low   = ~col_s2_q;
    row_n     = {2'b0, row_low[0]} + {2'b0, row_low[1]} +
                {2'b0, row_low[2]} + {2'b0, row_low[3]};
    case (row_low)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    base_cnt   = (row_idx_q == 2'd0) ? 2'd0 : fr_cnt_q;
    sum_cnt    = {1'b0, base_cnt} + row_n;
    frame_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    frame_code = (base_cnt == 2'd0 && row_n == 3'd1) ? {row_idx_q, col_idx} : fr_code_q;
    frame_done = tick && (row_idx_q == 2'd3);
    if (tick) begin
      row_d     = {row_q[2:0], row_q[3]};
      row_idx_d = row_idx_q + 2'd1;
      fr_cnt_d  = frame_cnt;
      fr_code_d = frame_code;
    end
  end

  // Debounce FSM; it only advances on the row-3 tick that closes a frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    press_evt = 1'b0;
    cnt_inc   = cnt_q + 1'b1;
    if (frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (frame_cnt == 2'd1) begin
            state_d = DEBOUNCE;
            cand_d  = frame_code;
            cnt_d   = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (frame_cnt == 2'd1 && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_V) begin
              state_d   = PRESSED;
              press_evt = 1'b1;
            end
          end else if (frame_cnt == 2'd1) begin
            cand_d = frame_code;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (frame_cnt == 2'd0) begin
            state_d = RELEASE;
            cnt_d   = CW'(1);
          end
        end
        RELEASE: begin
          if (frame_cnt == 2'd0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_V) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Event outputs; a clear that coincides with a press keeps only the new code.
  always_comb begin
    shifted     = {key_data_q, cand_q};
    key_valid_d = press_evt;
    key_code_d  = press_evt ? cand_q : key_code_q;
    key_down_d  = (state_d == PRESSED) || (state_d == RELEASE);
    key_data_d  = key_data_q;
    if (clr_i) begin
      key_data_d = press_evt ? {{(DIG_WIDTH*4-4){1'b0}}, cand_q} : '0;
    end else if (press_evt) begin
      key_data_d = shifted[DIG_WIDTH*4-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      presc_q     <= '0;
      row_q       <= 4'b1110;
      row_idx_q   <= 2'd0;
      fr_cnt_q    <= 2'd0;
      fr_code_q   <= 4'd0;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_down_q  <= 1'b0;
      key_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_s1_q    <= col_i;
      col_s2_q    <= col_s1_q;
      presc_q     <= presc_d;
      row_q       <= row_d;
      row_idx_q   <= row_idx_d;
      fr_cnt_q    <= fr_cnt_d;
      fr_code_q   <= fr_code_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      key_data_q  <= key_data_d;
    end
  end

  assign row_o       = row_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_down_o  = key_down_q;
  assign key_data_o  = key_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: a keypad model pulls columns low for held keys
// on the active row; expected codes of every press are queued and matched per pulse.
module tb_key_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  col_i;
  logic        clr_i;
  logic [3:0]  row_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic        key_down_o;
  logic [15:0] key_data_o;
  logic [1:0]  dbg_state_o;

  logic [15:0] keys;
  logic [15:0] exp_data;
  logic [3:0]  exp_q[$];
  int          n_vec;
  int          n_err;
  int          pulse_cnt;

  key_scan #(
    .CLK_IN_FREQ(1000),
    .SCAN_HZ(100),
    .DEBOUNCE_FRAMES(3),
    .DIG_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_i(col_i),
    .clr_i(clr_i),
    .row_o(row_o),
    .key_valid_o(key_valid_o),
    .key_code_o(key_code_o),
    .key_down_o(key_down_o),
    .key_data_o(key_data_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a held key at (r,c) pulls col c low while row r is driven low
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every pulse must match the next queued code
  always @(posedge clk) begin
    if (rst === 1'b1 && key_valid_o === 1'b1) begin
      pulse_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_pulse: observed code %0h expected no pulse", key_code_o);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        assert (key_code_o === e) else begin
          n_err++;
          $error("FAIL pulse_code: observed %0h expected %0h", key_code_o, e);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // return at the negedge right after row_o wraps 0111 -> 1110
  task automatic sync_frame();
    logic [3:0] prev;
    logic       found;
    prev  = row_o;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (row_o == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = row_o;
    end
    check("frame_sync", {31'b0, found}, 32'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; pulse_cnt = 0;
    rst = 1'b0; clr_i = 1'b0; keys = 16'h0; exp_data = 16'h0;

    // reset values
    wait_clks(3);
    check("rst_row", row_o, 4'b1110);
    check("rst_valid", key_valid_o, 1'b0);
    check("rst_code", key_code_o, 4'd0);
    check("rst_down", key_down_o, 1'b0);
    check("rst_data", key_data_o, 16'h0);
    check("rst_state", dbg_state_o, 2'd0);

    // row stepping every 10 clk
    rst = 1'b1;
    wait_clks(9);  check("row_hold", row_o, 4'b1110);
    wait_clks(1);  check("row_1", row_o, 4'b1101);
    wait_clks(10); check("row_2", row_o, 4'b1011);
    wait_clks(10); check("row_3", row_o, 4'b0111);
    wait_clks(10); check("row_wrap", row_o, 4'b1110);

    // single press of key 9 (row 2, col 1) with exact latency
    keys = 16'h1 << 9; exp_q.push_back(4'd9);
    exp_data = {exp_data[11:0], 4'd9};
    wait_clks(119);
    check("k9_early_valid", key_valid_o, 1'b0);
    check("k9_early_down", key_down_o, 1'b0);
    wait_clks(1);
    check("k9_valid", key_valid_o, 1'b1);
    check("k9_code", key_code_o, 4'd9);
    check("k9_data", key_data_o, 16'h0009);
    check("k9_down", key_down_o, 1'b1);
    check("k9_state", dbg_state_o, 2'd2);
    wait_clks(1);
    check("k9_pulse_end", key_valid_o, 1'b0);
    check("k9_held_down", key_down_o, 1'b1);
    wait_clks(79);
    check("k9_one_pulse", pulse_cnt, 1);
    keys = 16'h0;
    wait_clks(119);
    check("k9_rel_early", key_down_o, 1'b1);
    wait_clks(1);
    check("k9_rel_down", key_down_o, 1'b0);
    check("k9_rel_state", dbg_state_o, 2'd0);

    // bounce: key 6 present for one frame only
    keys = 16'h1 << 6;
    wait_clks(40);
    check("bounce_deb", dbg_state_o, 2'd1);
    keys = 16'h0;
    wait_clks(40);
    check("bounce_idle", dbg_state_o, 2'd0);
    wait_clks(40);
    check("bounce_down", key_down_o, 1'b0);
    check("bounce_nopulse", pulse_cnt, 1);

    // sequence 1,2,3,4 shifts out the old 9
    for (int k = 1; k <= 4; k++) begin
      keys = 16'h1 << k; exp_q.push_back(4'(k));
      exp_data = {exp_data[11:0], 4'(k)};
      wait_clks(120);
      check("seq_code", key_code_o, 4'(k));
      check("seq_data", key_data_o, exp_data);
      keys = 16'h0;
      wait_clks(120);
      check("seq_rel", key_down_o, 1'b0);
    end
    check("seq_final", key_data_o, 16'h1234);

    // clear coinciding with a press of key 15
    keys = 16'h1 << 15; exp_q.push_back(4'd15);
    wait_clks(119);
    clr_i = 1'b1;
    wait_clks(1);
    clr_i = 1'b0;
    check("clrp_valid", key_valid_o, 1'b1);
    check("clrp_data", key_data_o, 16'h000F);
    keys = 16'h0;
    wait_clks(120);
    check("clrp_rel", key_down_o, 1'b0);

    // plain clear
    clr_i = 1'b1;
    wait_clks(1);
    clr_i = 1'b0;
    check("clr_data", key_data_o, 16'h0);
    sync_frame();

    // keys 0 and 5 together: no event
    keys = 16'h0021;
    wait_clks(200);
    check("multi_state", dbg_state_o, 2'd0);
    check("multi_down", key_down_o, 1'b0);
    check("multi_nopulse", pulse_cnt, 6);
    keys = 16'h0020; exp_q.push_back(4'd5);
    wait_clks(120);
    check("k5_valid", key_valid_o, 1'b1);
    check("k5_data", key_data_o, 16'h0005);
    keys = 16'h0021;
    wait_clks(200);
    check("k5_add0_down", key_down_o, 1'b1);
    check("k5_add0_state", dbg_state_o, 2'd2);
    check("k5_add0_pulses", pulse_cnt, 7);
    keys = 16'h0;
    wait_clks(200);
    check("k5_rel", key_down_o, 1'b0);
    sync_frame();

    // reset in the 2nd debounce frame of key 3
    keys = 16'h1 << 3;
    wait_clks(60);
    check("mid_deb_state", dbg_state_o, 2'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_row", row_o, 4'b1110);
    check("mid_rst_down", key_down_o, 1'b0);
    check("mid_rst_code", key_code_o, 4'd0);
    check("mid_rst_data", key_data_o, 16'h0);
    check("mid_rst_state", dbg_state_o, 2'd0);
    wait_clks(3);
    rst = 1'b1; exp_q.push_back(4'd3);
    wait_clks(119);
    check("k3_early_valid", key_valid_o, 1'b0);
    check("k3_early_pulses", pulse_cnt, 7);
    wait_clks(1);
    check("k3_valid", key_valid_o, 1'b1);
    check("k3_code", key_code_o, 4'd3);
    check("k3_data", key_data_o, 16'h0003);
    check("k3_down", key_down_o, 1'b1);
    wait_clks(1);
    check("k3_pulse_end", key_valid_o, 1'b0);
    keys = 16'h0;
    wait_clks(200);
    check("k3_rel", key_down_o, 1'b0);
    check("total_pulses", pulse_cnt, 8);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
